// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day set controller and its
// sibling stopwatch/timer modes.
package clock_pkg;

   typedef enum logic [2:0] {
      RUN,
      EDIT_HRS,
      EDIT_MIN,
      EDIT_SEC,
      COMMIT
   } state_t;

   localparam int HRS_W = 5;
   localparam int MS_W  = 6;

   localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
   localparam logic [MS_W-1:0]  MIN_MAX = 6'd59;
   localparam logic [MS_W-1:0]  SEC_MAX = 6'd59;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HRS  = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   function automatic logic [1:0] field_of(input state_t s);
      case (s)
         EDIT_HRS: return FIELD_HRS;
         EDIT_MIN: return FIELD_MIN;
         EDIT_SEC: return FIELD_SEC;
         default:  return FIELD_NONE;
      endcase
   endfunction

   // Wrap is an explicit compare against the field maximum, never width overflow.
   function automatic logic [HRS_W-1:0] hrs_step(input logic [HRS_W-1:0] v, input logic up);
      if (up) return (v >= HRS_MAX) ? 5'd0 : v + 5'd1;
      else    return (v == 5'd0 || v > HRS_MAX) ? HRS_MAX : v - 5'd1;
   endfunction

   function automatic logic [MS_W-1:0] ms_step(input logic [MS_W-1:0] v,
                                                input logic [MS_W-1:0] max,
                                                input logic up);
      if (up) return (v >= max) ? 6'd0 : v + 6'd1;
      else    return (v == 6'd0 || v > max) ? max : v - 6'd1;
   endfunction

   function automatic logic [HRS_W-1:0] hrs_clamp(input logic [HRS_W-1:0] v);
      return (v > HRS_MAX) ? 5'd0 : v;
   endfunction

   function automatic logic [MS_W-1:0] ms_clamp(input logic [MS_W-1:0] v, input logic [MS_W-1:0] max);
      return (v > max) ? 6'd0 : v;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles; the count
// holds while en is low and clr restarts the period from zero.
module tick_prescaler #(
   parameter int CLK_HZ = 100000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
            tick  <= 1'b1;
         end else begin
            count <= count + W'(1);
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day controller: 1 Hz advance enable plus a button-driven
// hours/minutes/seconds edit sequence committed with a single load strobe.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BLINK_HALF = CLK_HZ / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             switch,
   input  logic [2:0]       mode,
   input  logic             btn_next,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic [HRS_W-1:0] cur_hrs,
   input  logic [MS_W-1:0]  cur_min,
   input  logic [MS_W-1:0]  cur_sec,
   output logic             tick_1hz,
   output logic             load,
   output logic [HRS_W-1:0] set_hrs,
   output logic [MS_W-1:0]  set_min,
   output logic [MS_W-1:0]  set_sec,
   output logic             run_en,
   output logic [1:0]       edit_field,
   output logic             blink
);

   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   state_t state, state_n;
   logic active, adjust, entering, editing_next;
   logic pre_en, pre_clr;
   logic [BW-1:0] blink_cnt;

   assign active = switch && (mode == 3'd0);

   always_comb begin
      state_n = state;
      case (state)
         RUN:      if (active && btn_next) state_n = EDIT_HRS;
         EDIT_HRS: if (!active) state_n = RUN; else if (btn_next) state_n = EDIT_MIN;
         EDIT_MIN: if (!active) state_n = RUN; else if (btn_next) state_n = EDIT_SEC;
         EDIT_SEC: if (!active) state_n = RUN; else if (btn_next) state_n = COMMIT;
         COMMIT:   state_n = RUN;
         default:  state_n = RUN;
      endcase
   end

   assign adjust       = active && !btn_next && (btn_up ^ btn_down);
   assign entering     = (state == RUN) && (state_n == EDIT_HRS);
   assign editing_next = state_n inside {EDIT_HRS, EDIT_MIN, EDIT_SEC};

   // Counting only when staying in (or returning to) RUN keeps tick_1hz quiet
   // on the first edit cycle; clearing on entry to COMMIT makes the first tick
   // land exactly CLK_HZ cycles after the load strobe.
   assign pre_en  = active && (state_n == RUN);
   assign pre_clr = (state_n == COMMIT);

   tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (pre_en),
      .clr  (pre_clr),
      .tick (tick_1hz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         load       <= 1'b0;
         edit_field <= FIELD_NONE;
         run_en     <= 1'b0;
         set_hrs    <= '0;
         set_min    <= '0;
         set_sec    <= '0;
      end else begin
         state      <= state_n;
         load       <= (state_n == COMMIT);
         edit_field <= field_of(state_n);
         run_en     <= active && (state_n == RUN);
         if (entering) begin
            set_hrs <= hrs_clamp(cur_hrs);
            set_min <= ms_clamp(cur_min, MIN_MAX);
            set_sec <= ms_clamp(cur_sec, SEC_MAX);
         end else if (adjust) begin
            case (state)
               EDIT_HRS: set_hrs <= hrs_step(set_hrs, btn_up);
               EDIT_MIN: set_min <= ms_step(set_min, MIN_MAX, btn_up);
               EDIT_SEC: set_sec <= ms_step(set_sec, SEC_MAX, btn_up);
               default:  ;
            endcase
         end
      end
   end

   // Blink phase runs continuously across field changes and restarts only on
   // a fresh entry from RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (editing_next && !entering) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end else begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end
   end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Controller for the time-of-day counter datapath: owns the 1 Hz tick that advances it and the load path that configures it.
- Runs a button-driven edit FSM (hours, then minutes, then seconds), keeps shadow copies of the fields being edited, and commits them with a single load strobe.
- Sits between the debounced button/switch logic and the hh:mm:ss counter; its edit-field and blink outputs drive the display.

Parameters:
- CLK_HZ, 100000000, clk cycles per second; tick period.
- BLINK_HALF, CLK_HZ/2, cycles per blink half-period in edit states.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- switch  in  1  clock enable switch
- mode  in  3  display/function mode; this block acts only when mode==0
- btn_next  in  1  single-cycle pulse, advance edit field
- btn_up  in  1  single-cycle pulse, increment selected field
- btn_down  in  1  single-cycle pulse, decrement selected field
- cur_hrs  in  5  counter's current hours
- cur_min  in  6  counter's current minutes
- cur_sec  in  6  counter's current seconds
- tick_1hz  out  1  one-cycle advance enable to the counter
- load  out  1  one-cycle strobe: counter takes set_* values
- set_hrs  out  5  shadow hours
- set_min  out  6  shadow minutes
- set_sec  out  6  shadow seconds
- run_en  out  1  counter may advance
- edit_field  out  2  0=none, 1=hrs, 2=min, 3=sec
- blink  out  1  display blank phase for the selected field

Behaviour:
- Active: active = switch & (mode==0).
- Reset (rst_n low, async):
  - State RUN; prescaler and blink counter 0.
  - set_* = 0; tick_1hz = 0; load = 0; edit_field = 0; blink = 0.
- FSM states: RUN, EDIT_HRS, EDIT_MIN, EDIT_SEC, COMMIT.
- RUN:
  - run_en = active.
  - The prescaler counts only while active. When it reaches CLK_HZ-1, it wraps to 0 and tick_1hz = 1 for that cycle.
  - While not active, the prescaler holds its value (no clear).
  - btn_next & active: capture cur_* into set_*, go to EDIT_HRS, clear the blink counter.
- EDIT_HRS / EDIT_MIN / EDIT_SEC:
  - run_en = 0; tick_1hz never asserts; prescaler held.
  - edit_field = 1/2/3.
  - btn_up: increment the selected field.
  - btn_down: decrement the selected field.
  - Wrap: hrs 23->0 and 0->23; min/sec 59->0 and 0->59.
  - btn_next advances HRS->MIN->SEC->COMMIT.
- Button priority (same cycle):
  - next beats up/down; up/down are ignored that cycle.
  - up & down together: no change.
- COMMIT (exactly one cycle):
  - load = 1; set_* stable.
  - Prescaler cleared to 0, so the first tick comes exactly CLK_HZ cycles after commit.
  - Next state RUN.
- Abort: active drops in any EDIT state -> RUN next cycle, no load; shadow values discarded (overwritten at next entry).
- Blink:
  - In EDIT states, the blink counter counts to BLINK_HALF-1, wraps, and toggles blink. blink starts 0 on entry.
  - In RUN/COMMIT, blink = 0.
- Out-of-range cur_*: a captured value >23 or >59 is forced to 0 at capture.
- Timing: all outputs registered, 1-cycle latency from button pulse to updated set_*/state.
- Width rules:
  - Prescaler width = $clog2(CLK_HZ).
  - Field arithmetic is done in field width with explicit wrap compare. It never relies on natural overflow.
- Reset mid-edit: returns to RUN with no load pulse.

Decomposition:
- Shared package clock_pkg:
  - State enum.
  - Constants HRS_MAX=23, MIN_MAX=59, SEC_MAX=59.
  - Field-width constants HRS_W=5, MS_W=6.
  - edit_field encodings.
- One natural sub-module: tick_prescaler.
  - Parameter CLK_HZ.
  - Inputs: en, clr.
  - Output: tick.
  - Reused by the stopwatch/timer modes.

Test Plan:
- Reset and free run: CLK_HZ=10, switch=1, mode=0 -> tick_1hz high on cycles 10, 20, 30 after reset release; load never asserts.
- Set sequence:
  - Stimulus: cur=12:34:56; next; up×12; next; down×35; next; up×4; next.
  - Response: set=00:59:00; load high exactly 1 cycle; first tick 10 cycles later.
- Priority:
  - In EDIT_MIN with set_min=5: up+down same cycle -> still 5.
  - next+up same cycle -> state EDIT_SEC, set_min=5.
- Abort: in EDIT_HRS, drop switch -> RUN next cycle, load stays 0, run_en=0; restore switch -> ticks resume from the held prescaler value.
- Mode gating: mode=2, switch=1 -> no ticks, btn_next ignored (edit_field stays 0).
- Async reset mid-EDIT_SEC with blink=1:
  - Assert rst_n=0 between clock edges -> outputs clear immediately.
  - Required: blink=0, edit_field=0, set_*=0, no load.
